eight_one_tdm_mux: RTL and testbench

- Time-division 8:1 multiplexer: the transmit end of the 1:8 demux path.
- Scans eight input channels round-robin, one slot per accepted beat.
- Emits one registered beat per slot carrying the data, the slot number (Sel) and an occupancy flag, so a downstream 1:8 demux can route each beat back to its channel.
- Sits between channel producers and a single serial/shared link.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/eight_one_tdm_mux_if.sv | 27 ++
 rtl/tdm_slot_counter.sv | 24 ++
 rtl/eight_one_tdm_mux.sv | 76 +++++++
 tb/tb_eight_one_tdm_mux.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the 8:1 transmit mux and the matching 1:8 receive demux.
// Both ends must agree on the slot numbering and on which slot opens a frame.
package tdm_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0] slot_t;

    localparam slot_t FRAME_SLOT0 = '0;
    localparam slot_t SLOT_LAST   = slot_t'(NUM_CH - 1);

    // Round-robin successor; the last slot wraps back to the frame start.
    function automatic slot_t next_slot(input slot_t s);
        return (s == SLOT_LAST) ? FRAME_SLOT0 : s + slot_t'(1);
    endfunction

endpackage

// File: rtl/eight_one_tdm_mux_if.sv
// Channel-side and link-side signals of the TDM mux.
// The master modport is the environment side and the slave modport is the mux side.
interface eight_one_tdm_mux_if #(
    parameter int WIDTH = 1
);

    logic [tdm_pkg::NUM_CH*WIDTH-1:0] I;
    logic [tdm_pkg::NUM_CH-1:0]       I_valid;
    logic [tdm_pkg::NUM_CH-1:0]       I_ready;
    logic [WIDTH-1:0]                 Y;
    tdm_pkg::slot_t                   Sel;
    logic                             Y_valid;
    logic                             Y_occ;
    logic                             Y_ready;
    logic                             frame_start;

    modport master (
        output I, I_valid, Y_ready,
        input  I_ready, Y, Sel, Y_valid, Y_occ, frame_start
    );

    modport slave (
        input  I, I_valid, Y_ready,
        output I_ready, Y, Sel, Y_valid, Y_occ, frame_start
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot pointer for the TDM scan: holds the next slot to emit and
// advances one slot (mod 8) on each enabled cycle.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    output slot_t slot_o
);

    slot_t slot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= FRAME_SLOT0;
        end else if (en_i) begin
            slot_q <= next_slot(slot_q);
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/eight_one_tdm_mux.sv
// Time-division 8:1 mux: every slot emits one registered beat tagged with its
// slot number and an occupancy flag, whether or not its channel had data.
module eight_one_tdm_mux
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    eight_one_tdm_mux_if.slave bus
);

    slot_t             slot;
    logic              load;
    logic [WIDTH-1:0]  slot_data;
    logic              slot_valid;
    logic [NUM_CH-1:0] i_ready;

    logic [WIDTH-1:0]  y_q;
    slot_t             sel_q;
    logic              y_valid_q;
    logic              y_occ_q;
    logic              frame_start_q;

    // The output register is free when empty or when its beat leaves this cycle.
    assign load = en & ~rst & (~y_valid_q | bus.Y_ready);

    tdm_slot_counter u_slot_counter (
        .clk    (clk),
        .rst    (rst),
        .en_i   (load),
        .slot_o (slot)
    );

    always_comb begin
        slot_data  = '0;
        slot_valid = 1'b0;
        i_ready    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (slot == slot_t'(k)) begin
                slot_data  = bus.I[k*WIDTH +: WIDTH];
                slot_valid = bus.I_valid[k];
                i_ready[k] = load & bus.I_valid[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q           <= '0;
            sel_q         <= FRAME_SLOT0;
            y_valid_q     <= 1'b0;
            y_occ_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (load) begin
            y_q           <= slot_data;
            sel_q         <= slot;
            y_valid_q     <= 1'b1;
            y_occ_q       <= slot_valid;
            frame_start_q <= (slot == FRAME_SLOT0);
        end else if (bus.Y_ready) begin
            // Drained with nothing to replace it; data fields keep their last value.
            y_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign bus.I_ready     = i_ready;
    assign bus.Y           = y_q;
    assign bus.Sel         = sel_q;
    assign bus.Y_valid     = y_valid_q;
    assign bus.Y_occ       = y_occ_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_eight_one_tdm_mux.sv
// Bench for the 8:1 TDM mux: directed scenarios plus a randomized loopback run,
// all scored against a slot-by-slot behavioural model and a beat scoreboard.
module tb_eight_one_tdm_mux;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    eight_one_tdm_mux_if #(.WIDTH(W)) bus ();

    eight_one_tdm_mux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: the beat the mux should be showing and the next slot to scan.
    int           m_slot = 0;
    logic [W-1:0] m_y    = '0;
    int           m_sel  = 0;
    bit           m_occ  = 0;
    bit           m_fs   = 0;
    bit           m_vld  = 0;

    // Every accepted channel beat, in acceptance order, awaiting delivery on the link.
    typedef struct {
        int           ch;
        logic [W-1:0] d;
    } beat_t;
    beat_t sb[$];

    logic [7:0] last_ready;

    task automatic step();
        bit           load;
        logic [7:0]   er;
        beat_t        b;
        logic [W-1:0] cur_d;
        bit           cur_v;
        bit           c_rst, c_en, c_yr;
        #1;
        c_rst = rst;
        c_en  = en;
        c_yr  = bus.Y_ready;
        cur_d = bus.I[m_slot*W +: W];
        cur_v = bus.I_valid[m_slot];
        load  = c_en && !c_rst && (!m_vld || c_yr);
        er    = (load && cur_v) ? 8'(1 << m_slot) : 8'h00;
        last_ready = bus.I_ready;
        chk("i_ready", bus.I_ready, er);
        // Downstream demux view: an occupied beat taken off the link goes back to channel Sel.
        if (!c_rst && m_vld && c_yr && m_occ) begin
            chk("sb_has_beat", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                b = sb.pop_front();
                chk("lb_channel", bus.Sel, b.ch);
                chk("lb_data", bus.Y, b.d);
            end
        end
        if (er != 8'h00) sb.push_back('{m_slot, cur_d});
        @(posedge clk);
        if (c_rst) begin
            m_slot = 0; m_y = '0; m_sel = 0; m_occ = 0; m_fs = 0; m_vld = 0;
            sb.delete();
        end else if (load) begin
            m_y    = cur_d;
            m_sel  = m_slot;
            m_occ  = cur_v;
            m_fs   = (m_slot == 0);
            m_vld  = 1;
            m_slot = (m_slot + 1) % 8;
        end else if (c_yr) begin
            m_vld = 0;
            m_fs  = 0;
        end
        @(negedge clk);
        chk("y_valid", bus.Y_valid, m_vld);
        chk("y", bus.Y, m_y);
        chk("sel", bus.Sel, m_sel);
        chk("y_occ", bus.Y_occ, m_occ);
        chk("frame_start", bus.frame_start, m_fs);
    endtask

    // Steps until the requested slot's beat is on Y; a missed target counts as a failure.
    task automatic step_until_sel(input int s, input string tag);
        bit hit = 0;
        for (int n = 0; n < 16 && !hit; n++) begin
            step();
            hit = bus.Y_valid && (bus.Sel == 3'(s));
        end
        chk(tag, hit, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses, stray;
        rst = 1'b1;
        en  = 1'b1;
        bus.Y_ready = 1'b1;
        bus.I_valid = 8'hFF;
        for (int k = 0; k < 8; k++) bus.I[k*W +: W] = W'(k);

        // 1: full frame of occupied slots
        repeat (3) step();
        chk("rst_y_valid", bus.Y_valid, 0);
        chk("rst_sel", bus.Sel, 0);
        chk("rst_i_ready", last_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t1_sel", bus.Sel, i % 8);
            chk("t1_y", bus.Y, i % 8);
            chk("t1_frame_start", bus.frame_start, (i % 8) == 0);
            chk("t1_occ", bus.Y_occ, 1);
            chk("t1_ready_walk", last_ready, 1 << (i % 8));
        end

        // 2: only channel 2 occupied
        bus.I_valid = 8'b0000_0100;
        pulses = 0;
        stray  = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t2_occ", bus.Y_occ, bus.Sel == 3'd2);
            if (last_ready == 8'h04) pulses++;
            else if (last_ready != 8'h00) stray++;
        end
        chk("t2_ready_pulses", pulses, 2);
        chk("t2_stray_ready", stray, 0);

        // 3: stall on the slot-3 beat
        bus.I_valid = 8'hFF;
        step_until_sel(3, "t3_reach_sel3");
        bus.Y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold_sel", bus.Sel, 3);
            chk("t3_hold_valid", bus.Y_valid, 1);
            chk("t3_no_ready", last_ready, 0);
        end
        bus.Y_ready = 1'b1;
        step();
        chk("t3_next_sel", bus.Sel, 4);

        // 4: scan paused after the slot-5 beat
        step_until_sel(5, "t4_reach_sel5");
        en = 1'b0;
        step();
        chk("t4_drained", bus.Y_valid, 0);
        step();
        step();
        en = 1'b1;
        step();
        chk("t4_resume_sel", bus.Sel, 6);
        chk("t4_resume_valid", bus.Y_valid, 1);

        // 5: reset while the slot-6 beat is stalled
        bus.Y_ready = 1'b0;
        step();
        chk("t5_stalled_sel", bus.Sel, 6);
        rst = 1'b1;
        step();
        chk("t5_rst_ready", last_ready, 0);
        chk("t5_rst_valid", bus.Y_valid, 0);
        chk("t5_rst_sel", bus.Sel, 0);
        rst = 1'b0;
        bus.Y_ready = 1'b1;
        step();
        chk("t5_first_sel", bus.Sel, 0);
        chk("t5_first_fs", bus.frame_start, 1);

        // 6: randomized loopback through the scoreboard
        for (int i = 0; i < 1000; i++) begin
            en          = ($urandom_range(0, 7) != 0);
            bus.Y_ready = ($urandom_range(0, 3) != 0);
            bus.I_valid = 8'($urandom);
            bus.I       = (8*W)'($urandom);
            step();
        end
        en = 1'b0;
        bus.Y_ready = 1'b1;
        step();
        step();
        chk("lb_leftover", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
